mips_muldiv_unit: RTL

//  Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_muldiv_sign.sv | 17 +
 rtl/mips_muldiv_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   XLEN   : operand width (only 32 is supported)
//   ITERS  : iteration cycles per MULT/MULTU/DIV/DIVU (equals XLEN)
//   muldiv_op_t    : 3-bit operation encoding presented on the op port
//   muldiv_state_t : sequencer states of the unit
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_sign.sv
// Combinational conditional two's-complement negate.
// Used with W=32 as an abs() helper on operand entry (neg = signed op & msb)
// and with W=32/64 for the sign fix-up of quotient, remainder and product.
//   x   in  W  value
//   neg in  1  negate when high
//   y   out W  neg ? -x : x
module mips_muldiv_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous reset, active-high
//   start in   1   request, sampled only while busy==0
//   op    in   3   muldiv_op_t (6 and 7 are ignored)
//   rs    in   32  operand A (dividend / multiplicand / MTHI/MTLO source)
//   rt    in   32  operand B (divisor / multiplier)
//   busy  out  1   high in RUN and FINISH; start is ignored while high
//   done  out  1   one-cycle pulse when hi/lo take a new mult/div result
//   hi    out  32  HI register (product[63:32] / remainder)
//   lo    out  32  LO register (product[31:0] / quotient)
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0; there is no back-pressure other than busy and no queuing.
// Operands are converted to magnitudes on entry; the 32 shift-add or
// restoring shift-subtract steps run unsigned on a separate accumulator,
// and signs are restored in FINISH when hi/lo are written.
module mips_muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state;
  logic [5:0]    count;
  logic [63:0]   acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0]   opb;      // mult: multiplicand magnitude; div: divisor magnitude
  logic          sign_a;
  logic          sign_b;
  logic          is_div;

  // Operand entry: magnitudes for signed ops, raw values for unsigned ops.
  logic        signed_req;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;

  assign signed_req = (op == MULT) || (op == DIV);
  assign rs_neg     = signed_req & rs[31];
  assign rt_neg     = signed_req & rt[31];

  mips_muldiv_sign #(.W(32)) u_abs_rs (.x(rs), .neg(rs_neg), .y(abs_rs));
  mips_muldiv_sign #(.W(32)) u_abs_rt (.x(rt), .neg(rt_neg), .y(abs_rt));

  // Multiply step: conditionally add multiplicand to the upper half, then
  // shift the 65-bit {carry, sum, low} right by one.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Restoring divide step. The shifted partial remainder keeps the bit that
  // falls out of acc[63], so divisors >= 2^31 are handled correctly.
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  assign rem_sh   = acc[63:31];
  assign div_diff = {1'b0, rem_sh} - {2'b00, opb};
  assign div_next = div_diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  // Result sign fix-up.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  mips_muldiv_sign #(.W(64)) u_fix_prod (.x(acc),        .neg(sign_a ^ sign_b), .y(prod_fix));
  mips_muldiv_sign #(.W(32)) u_fix_quot (.x(acc[31:0]),  .neg(sign_a ^ sign_b), .y(quot_fix));
  mips_muldiv_sign #(.W(32)) u_fix_rem  (.x(acc[63:32]), .neg(sign_a),          .y(rem_fix));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 6'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              MULT, MULTU: begin
                acc    <= {32'd0, abs_rt};
                opb    <= abs_rs;
                sign_a <= rs_neg;
                sign_b <= rt_neg;
                is_div <= 1'b0;
                count  <= 6'd0;
                state  <= RUN;
              end
              DIV, DIVU: begin
                acc    <= {32'd0, abs_rs};
                opb    <= abs_rt;
                sign_a <= rs_neg;
                sign_b <= rt_neg;
                is_div <= 1'b1;
                count  <= 6'd0;
                state  <= RUN;
              end
              MTHI:    hi <= rs;
              MTLO:    lo <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 6'd1;
          if (count == 6'(ITERS - 1)) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            // With a zero divisor every step "succeeds", leaving |rs| as the
            // remainder (restored to rs by the fix-up); only the quotient
            // needs forcing to all ones.
            lo <= (opb == 32'd0) ? 32'hFFFF_FFFF : quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
